idu_exu_pipe: RTL and testbench
===============================

Name: idu_exu_pipe

Overview:
- ID/EX pipeline register between the decode stage and the execute stage of the RV32I pipeline.
- Registers the decoded payload and control bits, and carries the valid/ready handshake in both directions.
- Detects load-use hazards against the instruction currently held in EX and inserts a one-cycle bubble.
- Accepts a synchronous flush from branch/jump resolution, and keeps wrapping stall and bubble counters for trace.

Parameters:
PAYLOAD_W, 192, width of the opaque decoded datapath bundle (pc, operands, imm, branch_pc, alu_opcode, funct3, flags).
CNT_W, 32, width of the performance counters.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
flush  input  1  kill the EX slot and any incoming instruction this cycle
valid_last  input  1  ID holds a valid instruction
ready_last  output  1  this stage accepts from ID this cycle
id_payload  input  PAYLOAD_W  decoded bundle from ID
id_rs1  input  5  source register 1 index
id_rs2  input  5  source register 2 index
id_use_rs1  input  1  instruction reads rs1
id_use_rs2  input  1  instruction reads rs2
id_rd  input  5  destination register
id_R_wen  input  1  register write enable
id_mem_ren  input  1  load
id_mem_wen  input  1  store
id_csr_wen  input  4  CSR write enables
valid_next  output  1  EX slot holds a valid instruction
ready_next  input  1  EX consumes this cycle
ex_payload  output  PAYLOAD_W  registered bundle
ex_rd  output  5  registered rd
ex_R_wen  output  1  registered, forced 0 when slot invalid
ex_mem_ren  output  1  registered, forced 0 when slot invalid
ex_mem_wen  output  1  registered, forced 0 when slot invalid
ex_csr_wen  output  4  registered, forced 0 when slot invalid
stall_cnt  output  CNT_W  cycles with load_use_stall asserted
bubble_cnt  output  CNT_W  bubbles inserted (stall or flush)

Behaviour:
- Reset (asynchronous, active-high): all outputs and registers go to 0 (valid_next=0, ex_* =0, both counters=0).
- Reset is honoured mid-stall and mid-flush with no residual state.
- Combinational signals:
  - hz = valid_next & ex_mem_ren & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))
  - load_use_stall = valid_last & hz & ~flush
  - advance = ~valid_next | ready_next
  - ready_last = flush | (advance & ~load_use_stall)
- Priority on each rising clock edge:
  1. flush: valid_next<=0, ex_R_wen/ex_mem_*/ex_csr_wen<=0. The incoming instruction is accepted and dropped. bubble_cnt+1 if valid_next or valid_last was 1.
  2. load_use_stall & advance: bubble. Same clearing as flush. ID is held (ready_last=0). bubble_cnt+1.
  3. valid_last & ready_last: load all id_* into ex_*, valid_next<=1. Latency is one cycle.
  4. advance & ~valid_last: valid_next<=0, control bits cleared.
  5. Otherwise (downstream stall): hold everything.
- stall_cnt+1 every cycle load_use_stall=1, including while EX is stalled.
- Both counters wrap modulo 2^CNT_W with no saturation.
- Payload and ex_rd load only in case 3. They may hold stale data while valid_next=0, but the control outputs are always 0 in that case.
- A stall lasts exactly one accepted EX cycle. After the bubble, the load has left EX and hz drops.
- Stores and non-loads in EX never cause a stall. rd=x0 never causes a stall.
- Simultaneous flush and stall: flush wins, and stall_cnt does not increment.

Test Plan:
- Reset released with no input -> valid_next=0, ex_R_wen=0, stall_cnt=0, bubble_cnt=0. Assert reset for 1 cycle at a random time -> same values.
- Back-to-back ALU ops with valid_last=1 and ready_next=1 -> each id_payload appears on ex_payload exactly one cycle later with valid_next=1, and ready_last stays 1.
- Hold ready_next=0 for 3 cycles with valid_next=1 -> ex_payload stable, ready_last=0, no counter change. Resumes on release.
- lw with id_rd=5 followed by add reading rs2=5, ready_next=1 -> one cycle with ready_last=0, then a bubble (valid_next=0, ex_R_wen=0), then the add is loaded. Counters: stall_cnt=1, bubble_cnt=1.
- Same sequence with rd=0, or with the first instruction a store -> no stall and stall_cnt stays 0.
- flush=1 while valid_next=1, valid_last=1 and a load-use stall is present -> next cycle valid_next=0, ex_mem_wen=0, bubble_cnt+1, stall_cnt unchanged, ready_last=1 during the flush.

Source files
------------

// File: rtl/idu_exu_pipe_if.sv
`default_nettype none
// ============================================================================
// idu_exu_pipe_if
// ID -> EX boundary: handshake plus the decoded bundle and its registered copy.
// Rev 1.0
// ============================================================================
interface idu_exu_pipe_if #(
  parameter int PAYLOAD_W = 192
);
  logic                 valid_last;
  logic                 ready_last;
  logic [PAYLOAD_W-1:0] id_payload;
  logic [4:0]           id_rs1;
  logic [4:0]           id_rs2;
  logic                 id_use_rs1;
  logic                 id_use_rs2;
  logic [4:0]           id_rd;
  logic                 id_R_wen;
  logic                 id_mem_ren;
  logic                 id_mem_wen;
  logic [3:0]           id_csr_wen;

  logic                 valid_next;
  logic                 ready_next;
  logic [PAYLOAD_W-1:0] ex_payload;
  logic [4:0]           ex_rd;
  logic                 ex_R_wen;
  logic                 ex_mem_ren;
  logic                 ex_mem_wen;
  logic [3:0]           ex_csr_wen;

  // Surrounding pipeline (ID producer + EX consumer)
  modport master (
    output valid_last, id_payload, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_R_wen, id_mem_ren, id_mem_wen, id_csr_wen, ready_next,
    input  ready_last, valid_next, ex_payload, ex_rd, ex_R_wen, ex_mem_ren,
           ex_mem_wen, ex_csr_wen
  );

  // The ID/EX pipeline register itself
  modport slave (
    input  valid_last, id_payload, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_R_wen, id_mem_ren, id_mem_wen, id_csr_wen, ready_next,
    output ready_last, valid_next, ex_payload, ex_rd, ex_R_wen, ex_mem_ren,
           ex_mem_wen, ex_csr_wen
  );
endinterface
`default_nettype wire

// File: rtl/idu_exu_pipe.sv
`default_nettype none
// ============================================================================
// idu_exu_pipe
// RV32I ID/EX pipeline register with load-use bubble, flush and trace counters.
// Rev 1.0
// ============================================================================
module idu_exu_pipe #(
  parameter int PAYLOAD_W = 192,
  parameter int CNT_W     = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  idu_exu_pipe_if.slave      bus,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [4:0]           rd_q, rd_d;
  logic                 valid_q, valid_d;
  logic                 rwen_q, rwen_d;
  logic                 mren_q, mren_d;
  logic                 mwen_q, mwen_d;
  logic [3:0]           csr_q, csr_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]     bubble_cnt_q, bubble_cnt_d;

  logic w_hz, w_stall, w_advance, w_ready;

  // Control bits are cleared whenever the slot empties, so mren_q alone implies a live load.
  assign w_hz = valid_q & mren_q & (rd_q != 5'd0) &
                ((bus.id_use_rs1 & (bus.id_rs1 == rd_q)) |
                 (bus.id_use_rs2 & (bus.id_rs2 == rd_q)));
  assign w_stall   = bus.valid_last & w_hz & ~flush;
  assign w_advance = ~valid_q | bus.ready_next;
  assign w_ready   = flush | (w_advance & ~w_stall);

  always_comb begin
    payload_d    = payload_q;
    rd_d         = rd_q;
    valid_d      = valid_q;
    rwen_d       = rwen_q;
    mren_d       = mren_q;
    mwen_d       = mwen_q;
    csr_d        = csr_q;
    stall_cnt_d  = w_stall ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;

    if (flush) begin
      valid_d = 1'b0;
      rwen_d  = 1'b0;
      mren_d  = 1'b0;
      mwen_d  = 1'b0;
      csr_d   = 4'd0;
      if (valid_q | bus.valid_last)
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else if (w_stall & w_advance) begin
      valid_d      = 1'b0;
      rwen_d       = 1'b0;
      mren_d       = 1'b0;
      mwen_d       = 1'b0;
      csr_d        = 4'd0;
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else if (bus.valid_last & w_ready) begin
      payload_d = bus.id_payload;
      rd_d      = bus.id_rd;
      valid_d   = 1'b1;
      rwen_d    = bus.id_R_wen;
      mren_d    = bus.id_mem_ren;
      mwen_d    = bus.id_mem_wen;
      csr_d     = bus.id_csr_wen;
    end else if (w_advance) begin
      valid_d = 1'b0;
      rwen_d  = 1'b0;
      mren_d  = 1'b0;
      mwen_d  = 1'b0;
      csr_d   = 4'd0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      payload_q    <= '0;
      rd_q         <= 5'd0;
      valid_q      <= 1'b0;
      rwen_q       <= 1'b0;
      mren_q       <= 1'b0;
      mwen_q       <= 1'b0;
      csr_q        <= 4'd0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      payload_q    <= payload_d;
      rd_q         <= rd_d;
      valid_q      <= valid_d;
      rwen_q       <= rwen_d;
      mren_q       <= mren_d;
      mwen_q       <= mwen_d;
      csr_q        <= csr_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.ready_last = w_ready;
  assign bus.valid_next = valid_q;
  assign bus.ex_payload = payload_q;
  assign bus.ex_rd      = rd_q;
  assign bus.ex_R_wen   = rwen_q;
  assign bus.ex_mem_ren = mren_q;
  assign bus.ex_mem_wen = mwen_q;
  assign bus.ex_csr_wen = csr_q;
  assign stall_cnt      = stall_cnt_q;
  assign bubble_cnt     = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_idu_exu_pipe.sv
`default_nettype none
// ============================================================================
// tb_idu_exu_pipe
// Directed scenarios plus randomized traffic against an abstract slot model.
// Rev 1.0
// ============================================================================
module tb_idu_exu_pipe;
  localparam int PW = 192;
  localparam int CW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic [CW-1:0] stall_cnt, bubble_cnt;

  idu_exu_pipe_if #(.PAYLOAD_W(PW)) bus ();

  idu_exu_pipe #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .bus        (bus),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Abstract picture of the EX slot: what instruction sits there, if any.
  logic          m_valid;
  logic [PW-1:0] m_payload;
  logic [4:0]    m_rd;
  logic          m_rwen, m_mren, m_mwen;
  logic [3:0]    m_csr;
  logic [CW-1:0] m_stalls, m_bubbles;

  function automatic logic [PW-1:0] rand_pl();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // A load sitting in EX whose rd the incoming instruction reads.
  function automatic logic m_load_use();
    logic reads;
    reads = (bus.id_use_rs1 && bus.id_rs1 == m_rd) || (bus.id_use_rs2 && bus.id_rs2 == m_rd);
    return bus.valid_last && !flush && m_valid && m_mren && (m_rd != 0) && reads;
  endfunction

  function automatic logic m_ready();
    logic slot_free;
    slot_free = !m_valid || bus.ready_next;
    return flush || (slot_free && !m_load_use());
  endfunction

  task automatic m_clear();
    m_valid = 0; m_payload = '0; m_rd = 0; m_rwen = 0; m_mren = 0; m_mwen = 0;
    m_csr = 0; m_stalls = 0; m_bubbles = 0;
  endtask

  task automatic drive(input logic v, input logic [PW-1:0] pl, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                       input logic [3:0] csr, input logic rn, input logic fl);
    bus.valid_last = v;  bus.id_payload = pl; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.id_use_rs1 = u1; bus.id_use_rs2 = u2; bus.id_rd = rd;   bus.id_R_wen = rw;
    bus.id_mem_ren = mr; bus.id_mem_wen = mw; bus.id_csr_wen = csr;
    bus.ready_next = rn; flush = fl;
  endtask

  task automatic drive_idle();
    drive(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  // One clock: the model decides what happens to the slot from the inputs in front of it.
  task automatic tick();
    logic lu, free, take;
    lu   = m_load_use();
    free = !m_valid || bus.ready_next;
    take = bus.valid_last && m_ready();
    @(posedge clock);
    if (lu) m_stalls++;
    if (flush) begin
      if (m_valid || bus.valid_last) m_bubbles++;
      m_valid = 0; m_rwen = 0; m_mren = 0; m_mwen = 0; m_csr = 0;
    end else if (lu && free) begin
      m_bubbles++;
      m_valid = 0; m_rwen = 0; m_mren = 0; m_mwen = 0; m_csr = 0;
    end else if (take) begin
      m_valid = 1; m_payload = bus.id_payload; m_rd = bus.id_rd; m_rwen = bus.id_R_wen;
      m_mren = bus.id_mem_ren; m_mwen = bus.id_mem_wen; m_csr = bus.id_csr_wen;
    end else if (free) begin
      m_valid = 0; m_rwen = 0; m_mren = 0; m_mwen = 0; m_csr = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_clear();
  endtask

  task automatic test_reset();
    logic [PW-1:0] pl;
    do_reset();
    #2;
    n_checks++; if (bus.valid_next !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", bus.valid_next); end
    n_checks++; if (bus.ex_R_wen !== 1'b0) begin n_fail++; $display("FAIL rst_rwen: got %0b want 0", bus.ex_R_wen); end
    n_checks++; if (stall_cnt !== 0) begin n_fail++; $display("FAIL rst_stall: got %0d want 0", stall_cnt); end
    n_checks++; if (bubble_cnt !== 0) begin n_fail++; $display("FAIL rst_bubble: got %0d want 0", bubble_cnt); end
    n_checks++; if (bus.ready_last !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", bus.ready_last); end
    // Fill the slot with a load, then pull reset asynchronously mid-cycle.
    pl = rand_pl();
    drive(1, pl, 0, 0, 0, 0, 5'd9, 1, 1, 0, 4'hf, 1, 0);
    tick();
    drive(1, rand_pl(), 5'd9, 0, 1, 0, 5'd3, 1, 0, 0, 0, 1, 0);
    #($urandom_range(1, 3));
    reset = 1'b1;
    #1;
    n_checks++; if (bus.valid_next !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b want 0", bus.valid_next); end
    n_checks++; if (bus.ex_R_wen !== 1'b0 || bus.ex_mem_ren !== 1'b0 || bus.ex_csr_wen !== 4'd0) begin
      n_fail++; $display("FAIL arst_ctl: got rwen=%0b mren=%0b csr=%0h want 0", bus.ex_R_wen, bus.ex_mem_ren, bus.ex_csr_wen);
    end
    n_checks++; if (stall_cnt !== 0 || bubble_cnt !== 0) begin
      n_fail++; $display("FAIL arst_cnt: got stall=%0d bubble=%0d want 0", stall_cnt, bubble_cnt);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_clear();
    drive_idle();
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] pl;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pl = rand_pl();
      drive(1, pl, 5'($urandom()), 5'($urandom()), 1, 1, 5'($urandom()), 1, 0, 0, 0, 1, 0);
      #2;
      n_checks++; if (bus.ready_last !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %0b want 1", i, bus.ready_last); end
      tick();
      n_checks++; if (bus.valid_next !== 1'b1 || bus.ex_payload !== pl) begin
        n_fail++; $display("FAIL b2b_payload[%0d]: got v=%0b %0h want v=1 %0h", i, bus.valid_next, bus.ex_payload, pl);
      end
    end
  endtask

  task automatic test_downstream_stall();
    logic [PW-1:0] pa, pb;
    do_reset();
    pa = rand_pl(); pb = rand_pl();
    drive(1, pa, 1, 2, 1, 1, 5'd4, 1, 0, 0, 0, 1, 0);
    tick();
    drive(1, pb, 3, 4, 1, 1, 5'd6, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #2;
      n_checks++; if (bus.ready_last !== 1'b0) begin n_fail++; $display("FAIL hold_ready[%0d]: got %0b want 0", i, bus.ready_last); end
      tick();
      n_checks++; if (bus.valid_next !== 1'b1 || bus.ex_payload !== pa) begin
        n_fail++; $display("FAIL hold_payload[%0d]: got v=%0b %0h want v=1 %0h", i, bus.valid_next, bus.ex_payload, pa);
      end
      n_checks++; if (stall_cnt !== 0 || bubble_cnt !== 0) begin
        n_fail++; $display("FAIL hold_cnt[%0d]: got %0d/%0d want 0/0", i, stall_cnt, bubble_cnt);
      end
    end
    bus.ready_next = 1'b1;
    #2;
    n_checks++; if (bus.ready_last !== 1'b1) begin n_fail++; $display("FAIL resume_ready: got %0b want 1", bus.ready_last); end
    tick();
    n_checks++; if (bus.ex_payload !== pb) begin n_fail++; $display("FAIL resume_payload: got %0h want %0h", bus.ex_payload, pb); end
  endtask

  task automatic test_load_use();
    logic [PW-1:0] padd;
    do_reset();
    padd = rand_pl();
    drive(1, rand_pl(), 0, 0, 0, 0, 5'd5, 1, 1, 0, 0, 1, 0);
    tick();
    drive(1, padd, 5'd3, 5'd5, 1, 1, 5'd7, 1, 0, 0, 0, 1, 0);
    #2;
    n_checks++; if (bus.ready_last !== 1'b0) begin n_fail++; $display("FAIL lu_ready: got %0b want 0", bus.ready_last); end
    tick();
    n_checks++; if (bus.valid_next !== 1'b0 || bus.ex_R_wen !== 1'b0) begin
      n_fail++; $display("FAIL lu_bubble: got v=%0b rwen=%0b want 0/0", bus.valid_next, bus.ex_R_wen);
    end
    n_checks++; if (bus.ready_last !== 1'b1) begin n_fail++; $display("FAIL lu_release: got %0b want 1", bus.ready_last); end
    tick();
    n_checks++; if (bus.valid_next !== 1'b1 || bus.ex_payload !== padd || bus.ex_rd !== 5'd7) begin
      n_fail++; $display("FAIL lu_load: got v=%0b rd=%0d %0h want v=1 rd=7 %0h", bus.valid_next, bus.ex_rd, bus.ex_payload, padd);
    end
    n_checks++; if (stall_cnt !== 1 || bubble_cnt !== 1) begin
      n_fail++; $display("FAIL lu_cnt: got %0d/%0d want 1/1", stall_cnt, bubble_cnt);
    end
  endtask

  task automatic test_no_stall();
    do_reset();
    drive(1, rand_pl(), 0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 1, 0);
    tick();
    drive(1, rand_pl(), 5'd0, 5'd0, 1, 1, 5'd7, 1, 0, 0, 0, 1, 0);
    #2;
    n_checks++; if (bus.ready_last !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %0b want 1", bus.ready_last); end
    tick();
    drive(1, rand_pl(), 5'd1, 5'd2, 1, 1, 5'd5, 0, 0, 1, 0, 1, 0);
    tick();
    drive(1, rand_pl(), 5'd3, 5'd5, 1, 1, 5'd8, 1, 0, 0, 0, 1, 0);
    #2;
    n_checks++; if (bus.ready_last !== 1'b1) begin n_fail++; $display("FAIL st_ready: got %0b want 1", bus.ready_last); end
    tick();
    n_checks++; if (stall_cnt !== 0 || bubble_cnt !== 0) begin
      n_fail++; $display("FAIL nostall_cnt: got %0d/%0d want 0/0", stall_cnt, bubble_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, rand_pl(), 0, 0, 0, 0, 5'd5, 1, 1, 1, 4'h3, 1, 0);
    tick();
    drive(1, rand_pl(), 5'd5, 5'd1, 1, 1, 5'd7, 1, 0, 1, 0, 1, 1);
    #2;
    n_checks++; if (bus.ready_last !== 1'b1) begin n_fail++; $display("FAIL fl_ready: got %0b want 1", bus.ready_last); end
    tick();
    n_checks++; if (bus.valid_next !== 1'b0 || bus.ex_mem_wen !== 1'b0 || bus.ex_mem_ren !== 1'b0 || bus.ex_csr_wen !== 4'd0) begin
      n_fail++; $display("FAIL fl_slot: got v=%0b mwen=%0b mren=%0b csr=%0h want 0", bus.valid_next, bus.ex_mem_wen, bus.ex_mem_ren, bus.ex_csr_wen);
    end
    n_checks++; if (bubble_cnt !== 1 || stall_cnt !== 0) begin
      n_fail++; $display("FAIL fl_cnt: got bubble=%0d stall=%0d want 1/0", bubble_cnt, stall_cnt);
    end
    drive_idle();
  endtask

  task automatic test_random();
    logic [PW-1:0] pl;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      pl = rand_pl();
      drive(($urandom_range(0, 9) < 7), pl, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
            1'($urandom()), 1'($urandom()), 5'($urandom_range(0, 5)), 1'($urandom()),
            ($urandom_range(0, 9) < 4), 1'($urandom()), 4'($urandom()),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0));
      if (i == 200) begin
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_clear();
        continue;
      end
      #2;
      n_checks++; if (bus.ready_last !== m_ready()) begin
        n_fail++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", i, bus.ready_last, m_ready());
      end
      tick();
      n_checks++; if (bus.valid_next !== m_valid || bus.ex_R_wen !== m_rwen || bus.ex_mem_ren !== m_mren ||
                      bus.ex_mem_wen !== m_mwen || bus.ex_csr_wen !== m_csr) begin
        n_fail++; $display("FAIL rnd_ctl[%0d]: got v%0b r%0b l%0b s%0b c%0h want v%0b r%0b l%0b s%0b c%0h", i,
          bus.valid_next, bus.ex_R_wen, bus.ex_mem_ren, bus.ex_mem_wen, bus.ex_csr_wen,
          m_valid, m_rwen, m_mren, m_mwen, m_csr);
      end
      if (m_valid) begin
        n_checks++; if (bus.ex_payload !== m_payload || bus.ex_rd !== m_rd) begin
          n_fail++; $display("FAIL rnd_data[%0d]: got rd=%0d %0h want rd=%0d %0h", i, bus.ex_rd, bus.ex_payload, m_rd, m_payload);
        end
      end
      n_checks++; if (stall_cnt !== m_stalls || bubble_cnt !== m_bubbles) begin
        n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt, bubble_cnt, m_stalls, m_bubbles);
      end
    end
  endtask

  initial begin
    m_clear();
    drive_idle();
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_back_to_back();
    test_downstream_stall();
    test_load_use();
    test_no_stall();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
